vector_mem_reader: RTL
======================

// Module: vector_mem_reader
// PURPOSE
//  Read-side counterpart of the writeback stage's data-memory writes. On start, walks a range of
//  vector words in data memory (vectorSize lanes x registerSize bits each). Serialises each word
//  lane by lane onto a valid/ready byte stream for host/debug readout after a kernel runs.
//  Sits beside the processor on the data-memory read port.
// PARAMETERS
//  registerSize  8  bits per lane; also the stream data width
//  vectorSize    4  lanes per memory word
//  addrWidth     8  data-memory address width, in words
// PORTS
//  clk         in   1                          clock, rising edge
//  rst         in   1                          asynchronous reset, active-low
//  start       in   1                          begin a dump; sampled only in IDLE
//  baseAddr    in   addrWidth                  first word address, latched on start
//  wordCount   in   addrWidth+1                number of words to dump, latched on start
//  busy        out  1                          high from the cycle after start until DONE
//  done        out  1                          one-cycle pulse when the dump completes
//  memRdEn     out  1                          memory read strobe
//  memAddr     out  addrWidth                  memory read address
//  memRdData   in   vectorSize*registerSize    read data; valid 1 cycle after memRdEn; lane0 = [registerSize-1:0]
//  outData     out  registerSize               stream byte
//  outValid    out  1                          stream valid
//  outReady    in   1                          stream ready
//  outLast     out  1                          marks the final byte of the dump
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE. All outputs 0; internal address, word counter, lane index and buffer cleared.
//    Reset mid-dump aborts immediately with no done pulse.
//  - FSM: IDLE -> READ -> WAIT -> SEND -> (READ | DONE) -> IDLE.
//  - IDLE: start=1 latches baseAddr and wordCount.
//    - wordCount==0: go to DONE; no memory read, no stream bytes.
//    - Otherwise: go to READ.
//  - READ (1 cycle): memRdEn=1, memAddr=current address. memRdEn is 0 in every other state.
//  - WAIT (1 cycle): capture memRdData into the lane buffer; lane index=0.
//  - SEND: outValid=1, outData=buffer lane[index].
//    - Handshake is outValid&&outReady at a clock edge.
//    - outData and outLast hold stable while outValid&&!outReady; outValid never drops without a handshake.
//    - On handshake at lane vectorSize-1:
//      - if more words remain: address+1, words-1, go to READ;
//      - else: go to DONE.
//    - Otherwise the lane index increments.
//  - Latency: start at edge N gives memRdEn high in cycle N+1 and first outValid in cycle N+3.
//    Per word with outReady held high: vectorSize+2 cycles.
//  - Address wraps modulo 2^addrWidth; 0xFF+1 = 0x00, with no error.
//  - outLast=1 only on the final stream byte (see CONFIGURATION).
//  - DONE (1 cycle): done=1, busy=0, then IDLE.
//  - busy=1 in READ, WAIT and SEND.
//  - start while not in IDLE is ignored. start in the DONE cycle is also ignored.
//  - start and rst deassertion in the same cycle: start is honoured on the first edge after rst rises.
// CONFIGURATION
//  VECTOR_MEM_READER_CHECKSUM_EN
//   - Defined: maintain a registerSize-bit XOR of every lane byte sent, cleared on start.
//     After the last data byte, add a CSUM state that presents the XOR with outLast=1.
//     DONE follows that handshake. wordCount==0 still emits no bytes.
//   - Undefined: no CSUM state; outLast is on lane vectorSize-1 of the final word.
// TESTING
//  1. baseAddr=0x10, wordCount=1, mem[0x10]=0x44332211, outReady=1
//     -> memRdEn@N+1 addr 0x10; bytes 11,22,33,44 at N+3..N+6; outLast on 44; done@N+7.
//  2. wordCount=0
//     -> no memRdEn, no outValid; done pulses the cycle after start; busy stays 0.
//  3. baseAddr=0xFF, wordCount=2
//     -> reads 0xFF then 0x00 (wrap); 8 bytes total; outLast on the 8th only.
//  4. outReady held low 5 cycles on lane 2
//     -> outValid and outData frozen for those cycles; no byte lost or duplicated; lane order preserved.
//  5. rst pulled low during SEND of word 1 of 3
//     -> all outputs 0 asynchronously; no done. A fresh start afterwards dumps correctly from its new baseAddr.
//  6. CHECKSUM_EN, word 0x44332211
//     -> bytes 11,22,33,44 then 0x44 (XOR); outLast on the checksum byte only. start pulses during busy are ignored.

Source files
------------

// File: rtl/vector_mem_reader.sv
// Walks a range of data-memory vector words and streams them out lane by lane on a valid/ready byte port.
// Optional VECTOR_MEM_READER_CHECKSUM_EN appends an XOR checksum byte after the last data byte.
module vector_mem_reader #(
    parameter int registerSize = 8,
    parameter int vectorSize   = 4,
    parameter int addrWidth    = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [addrWidth-1:0]               baseAddr,
    input  logic [addrWidth:0]                 wordCount,
    output logic                               busy,
    output logic                               done,
    output logic                               memRdEn,
    output logic [addrWidth-1:0]               memAddr,
    input  logic [vectorSize*registerSize-1:0] memRdData,
    output logic [registerSize-1:0]            outData,
    output logic                               outValid,
    input  logic                               outReady,
    output logic                               outLast
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | memory read strobe for the current word
    // WAIT  | read data returns, captured into the lane buffer
    // SEND  | lanes presented on the stream one per handshake
    // CSUM  | checksum byte presented (checksum build only)
    // DONE  | one-cycle completion pulse
`ifdef VECTOR_MEM_READER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SEND, S_CSUM, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SEND, S_DONE} state_t;
`endif

    localparam int LANE_W = (vectorSize > 1) ? $clog2(vectorSize) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(vectorSize - 1);
    localparam logic [addrWidth:0] ONE_WORD = (addrWidth+1)'(1);

    state_t                  state;
    logic [addrWidth-1:0]    addr;
    logic [addrWidth:0]      words;
    logic [LANE_W-1:0]       lane;
    logic [LANE_W-1:0]       lane_nxt;
    logic [registerSize-1:0] lanes [vectorSize];
    logic                    last_word;
`ifdef VECTOR_MEM_READER_CHECKSUM_EN
    logic [registerSize-1:0] csum;
`endif

    assign lane_nxt  = lane + 1'b1;
    assign last_word = (words == ONE_WORD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            addr     <= '0;
            words    <= '0;
            lane     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            memRdEn  <= 1'b0;
            memAddr  <= '0;
            outData  <= '0;
            outValid <= 1'b0;
            outLast  <= 1'b0;
            for (int i = 0; i < vectorSize; i++) lanes[i] <= '0;
`ifdef VECTOR_MEM_READER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            done    <= 1'b0;
            memRdEn <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr  <= baseAddr;
                        words <= wordCount;
`ifdef VECTOR_MEM_READER_CHECKSUM_EN
                        csum  <= '0;
`endif
                        if (wordCount == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            busy    <= 1'b1;
                            memRdEn <= 1'b1;
                            memAddr <= baseAddr;
                            state   <= S_READ;
                        end
                    end
                end
                S_READ: state <= S_WAIT;
                S_WAIT: begin
                    for (int i = 0; i < vectorSize; i++)
                        lanes[i] <= memRdData[i*registerSize +: registerSize];
                    lane     <= '0;
                    outValid <= 1'b1;
                    outData  <= memRdData[registerSize-1:0];
`ifdef VECTOR_MEM_READER_CHECKSUM_EN
                    outLast  <= 1'b0;
`else
                    outLast  <= (LAST_LANE == '0) && last_word;
`endif
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (outReady) begin
`ifdef VECTOR_MEM_READER_CHECKSUM_EN
                        csum <= csum ^ outData;
`endif
                        if (lane == LAST_LANE) begin
                            if (!last_word) begin
                                addr     <= addr + 1'b1;
                                memAddr  <= addr + 1'b1;
                                words    <= words - 1'b1;
                                memRdEn  <= 1'b1;
                                outValid <= 1'b0;
                                outLast  <= 1'b0;
                                outData  <= '0;
                                state    <= S_READ;
                            end else begin
`ifdef VECTOR_MEM_READER_CHECKSUM_EN
                                // present the running XOR including the byte just accepted
                                outData  <= csum ^ outData;
                                outLast  <= 1'b1;
                                state    <= S_CSUM;
`else
                                outValid <= 1'b0;
                                outLast  <= 1'b0;
                                outData  <= '0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                state    <= S_DONE;
`endif
                            end
                        end else begin
                            lane    <= lane_nxt;
                            outData <= lanes[lane_nxt];
`ifndef VECTOR_MEM_READER_CHECKSUM_EN
                            outLast <= (lane_nxt == LAST_LANE) && last_word;
`endif
                        end
                    end
                end
`ifdef VECTOR_MEM_READER_CHECKSUM_EN
                S_CSUM: begin
                    if (outReady) begin
                        outValid <= 1'b0;
                        outLast  <= 1'b0;
                        outData  <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
